hmr_dmr_multi_ctrl: RTL and testbench
=====================================

// Module: hmr_dmr_multi_ctrl
// PURPOSE
//  Parametrised DMR lockstep controller for NumGrps core pairs; one independent FSM per group.
//  Handles mode entry/exit, setback-based re-execution, rapid-recovery request/done handshake
//    with timeout, fault latching and saturating per-group mismatch counters.
//  Sits between the HMR config registers (plain q/qe-style inputs) and the core-pair checkers.
// PARAMETERS
//  NumGrps         4     number of DMR core pairs controlled
//  DMRFixed        1'b0  groups permanently in DMR; dmr_enable_i ignored
//  DefaultInDMR    DMRFixed  reset mode is DMR_RUN (else NON_DMR)
//  RapidRecovery   1'b0  rapid-recovery path present; if 0, errors always use setback
//  SetbackCycles   4     setback_o high time per error (>=1)
//  RecoveryTimeout 256   max DMR_RESTORE cycles before fault (>=2)
//  CntWidth        8     mismatch counter width
// PORTS
//  clk_i            in  1                 clock
//  rst_i            in  1                 synchronous active-high reset
//  dmr_enable_i     in  NumGrps           per-group DMR request (level)
//  rapid_rec_en_i   in  NumGrps           use recovery instead of setback on error
//  force_recovery_i in  NumGrps           1-cycle pulse: force DMR_RESTORE
//  fetch_en_i       in  NumGrps           cores of group started
//  cores_synch_i    in  NumGrps           cores of group synchronised
//  dmr_error_i      in  NumGrps           lockstep mismatch detected (1-cycle per event)
//  recovery_done_i  in  NumGrps           recovery unit finished for group
//  fault_clr_i      in  NumGrps           1-cycle pulse: leave DMR_FAULT
//  mismatch_clr_i   in  NumGrps           1-cycle pulse: clear mismatch counter
//  setback_o        out NumGrps           core setback/re-execute
//  recovery_req_o   out NumGrps           recovery request (level, held in DMR_RESTORE)
//  grp_in_indep_o   out NumGrps           group in NON_DMR
//  fault_o          out NumGrps           group in DMR_FAULT
//  mismatch_cnt_o   out NumGrps*CntWidth  saturating mismatch counters
// BEHAVIOUR
//  Reset: state DefaultDMRMode, all counters 0, setback_o/recovery_req_o/fault_o 0,
//    grp_in_indep_o = (DefaultDMRMode==NON_DMR). All outputs registered or decoded from state.
//  States per group: NON_DMR, DMR_RUN, DMR_SETBACK, DMR_RESTORE, DMR_FAULT.
//  NON_DMR -> DMR_RUN when dmr_enable_i && (!fetch_en_i || cores_synch_i).
//  DMR_RUN, highest priority first:
//    dmr_error_i: cnt++ (saturates at 2^CntWidth-1);
//      -> DMR_RESTORE if RapidRecovery && rapid_rec_en_i; else -> DMR_SETBACK.
//    force_recovery_i && RapidRecovery: -> DMR_RESTORE, cnt unchanged.
//    !dmr_enable_i && !DMRFixed: -> NON_DMR.
//  DMR_SETBACK: setback_o high exactly SetbackCycles cycles, starting the cycle after the error;
//    then -> DMR_RUN. A dmr_error_i here increments cnt but does not restart the window.
//  DMR_RESTORE: recovery_req_o high from entry cycle; timer counts cycles in state.
//    recovery_done_i -> DMR_RUN (done wins over timeout in the same cycle).
//    timer == RecoveryTimeout-1 without done -> DMR_FAULT. dmr_error_i: cnt++ only.
//  DMR_FAULT: fault_o high; fault_clr_i -> NON_DMR (DMR_RUN if DMRFixed). Other inputs ignored.
//  dmr_enable_i drops in SETBACK/RESTORE: no exit; exit is evaluated on return to DMR_RUN.
//  mismatch_clr_i same cycle as increment: clear wins (counter = 0).
//  Reset asserted mid-restore/setback: next cycle all outputs at reset values, timers 0.
//  Groups fully independent; no cross-group coupling.
// STRUCTURE
//  dmr_grp_mode_e (5 states) and mode localparam go in recovery_pkg.
//  One sub-module hmr_dmr_grp_fsm (FSM + setback/timeout timer + mismatch counter),
//    instantiated NumGrps times in a generate loop; top only slices ports.
// TESTING
//  Reset, DefaultInDMR=0 -> grp_in_indep_o=4'hF, other outputs 0, mismatch_cnt_o=0.
//  grp0 enable=1, fetch_en=0 -> DMR_RUN next cycle; error pulse -> setback_o[0] high 4 cycles, cnt0=1.
//  RapidRecovery=1, rapid_rec_en=1, error -> recovery_req_o[0] high; done after 10 cycles -> DMR_RUN.
//  RecoveryTimeout=16, no done -> fault_o high on cycle 16 after entry; fault_clr -> NON_DMR.
//  CntWidth=2, 5 errors -> cnt=3 (saturated); mismatch_clr together with error -> cnt=0.
//  Errors on grp1 and grp3 in same cycle -> both setback, grp0/grp2 unaffected; DMRFixed ignores enable=0.

Source files
------------

// File: rtl/recovery_pkg.sv
// Shared DMR group mode encoding and reset-mode helper for the HMR lockstep controllers.
// Imported by the per-group FSM and the multi-group top.
package recovery_pkg;

   typedef enum logic [2:0] {
      NON_DMR,
      DMR_RUN,
      DMR_SETBACK,
      DMR_RESTORE,
      DMR_FAULT
   } dmr_grp_mode_e;

   localparam dmr_grp_mode_e DmrActiveMode = DMR_RUN;

   function automatic dmr_grp_mode_e default_dmr_mode(input logic in_dmr);
      return in_dmr ? DmrActiveMode : NON_DMR;
   endfunction

endpackage

// File: rtl/hmr_dmr_grp_fsm.sv
// One DMR core pair: mode FSM, shared setback/restore timer, saturating mismatch counter.
// Outputs are decoded from registered state (one-cycle reaction); no backpressure, inputs are levels/pulses.
module hmr_dmr_grp_fsm
   import recovery_pkg::*;
#(
   parameter logic        DMRFixed        = 1'b0,
   parameter logic        DefaultInDMR    = DMRFixed,
   parameter logic        RapidRecovery   = 1'b0,
   parameter int unsigned SetbackCycles   = 4,
   parameter int unsigned RecoveryTimeout = 256,
   parameter int unsigned CntWidth        = 8
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                dmr_enable_i,
   input  logic                rapid_rec_en_i,
   input  logic                force_recovery_i,
   input  logic                fetch_en_i,
   input  logic                cores_synch_i,
   input  logic                dmr_error_i,
   input  logic                recovery_done_i,
   input  logic                fault_clr_i,
   input  logic                mismatch_clr_i,
   output logic                setback_o,
   output logic                recovery_req_o,
   output logic                grp_in_indep_o,
   output logic                fault_o,
   output logic [CntWidth-1:0] mismatch_cnt_o
);

   localparam int unsigned TmrMax = (SetbackCycles > RecoveryTimeout) ? SetbackCycles : RecoveryTimeout;
   localparam int unsigned TmrW   = $clog2(TmrMax) + 1;
   localparam logic [TmrW-1:0]     SetbackLast = TmrW'(SetbackCycles - 1);
   localparam logic [TmrW-1:0]     TimeoutLast = TmrW'(RecoveryTimeout - 1);
   localparam logic [CntWidth-1:0] CntMax      = '1;
   localparam dmr_grp_mode_e       ResetMode   = default_dmr_mode(DefaultInDMR);

   dmr_grp_mode_e       state_q, state_d;
   logic [TmrW-1:0]     tmr_q, tmr_d;
   logic [CntWidth-1:0] cnt_q, cnt_d;
   logic                cnt_inc;
   logic                enable_eff;

   assign enable_eff = dmr_enable_i | DMRFixed;

   // Timer is zero on every entry into SETBACK/RESTORE because it defaults to 0 elsewhere.
   always_comb begin
      state_d = state_q;
      tmr_d   = '0;
      cnt_inc = 1'b0;
      unique case (state_q)
         NON_DMR: begin
            if (enable_eff && (!fetch_en_i || cores_synch_i)) state_d = DMR_RUN;
         end
         DMR_RUN: begin
            if (dmr_error_i) begin
               cnt_inc = 1'b1;
               state_d = (RapidRecovery && rapid_rec_en_i) ? DMR_RESTORE : DMR_SETBACK;
            end else if (force_recovery_i && RapidRecovery) begin
               state_d = DMR_RESTORE;
            end else if (!enable_eff) begin
               state_d = NON_DMR;
            end
         end
         DMR_SETBACK: begin
            cnt_inc = dmr_error_i;
            if (tmr_q == SetbackLast) state_d = DMR_RUN;
            else                      tmr_d   = tmr_q + TmrW'(1);
         end
         DMR_RESTORE: begin
            cnt_inc = dmr_error_i;
            if (recovery_done_i)           state_d = DMR_RUN;
            else if (tmr_q == TimeoutLast) state_d = DMR_FAULT;
            else                           tmr_d   = tmr_q + TmrW'(1);
         end
         DMR_FAULT: begin
            if (fault_clr_i) state_d = DMRFixed ? DMR_RUN : NON_DMR;
         end
         default: state_d = ResetMode;
      endcase

      if (mismatch_clr_i)                  cnt_d = '0;
      else if (cnt_inc && cnt_q != CntMax) cnt_d = cnt_q + CntWidth'(1);
      else                                 cnt_d = cnt_q;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ResetMode;
         tmr_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         tmr_q   <= tmr_d;
         cnt_q   <= cnt_d;
      end
   end

   assign setback_o      = (state_q == DMR_SETBACK);
   assign recovery_req_o = (state_q == DMR_RESTORE);
   assign grp_in_indep_o = (state_q == NON_DMR);
   assign fault_o        = (state_q == DMR_FAULT);
   assign mismatch_cnt_o = cnt_q;

endmodule

// File: rtl/hmr_dmr_multi_ctrl.sv
// DMR lockstep controller for NumGrps independent core pairs; one hmr_dmr_grp_fsm per group.
// Registered-state outputs, one-cycle reaction to config/checker inputs; no backpressure.
module hmr_dmr_multi_ctrl
   import recovery_pkg::*;
#(
   parameter int unsigned NumGrps         = 4,
   parameter logic        DMRFixed        = 1'b0,
   parameter logic        DefaultInDMR    = DMRFixed,
   parameter logic        RapidRecovery   = 1'b0,
   parameter int unsigned SetbackCycles   = 4,
   parameter int unsigned RecoveryTimeout = 256,
   parameter int unsigned CntWidth        = 8
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic [NumGrps-1:0]          dmr_enable_i,
   input  logic [NumGrps-1:0]          rapid_rec_en_i,
   input  logic [NumGrps-1:0]          force_recovery_i,
   input  logic [NumGrps-1:0]          fetch_en_i,
   input  logic [NumGrps-1:0]          cores_synch_i,
   input  logic [NumGrps-1:0]          dmr_error_i,
   input  logic [NumGrps-1:0]          recovery_done_i,
   input  logic [NumGrps-1:0]          fault_clr_i,
   input  logic [NumGrps-1:0]          mismatch_clr_i,
   output logic [NumGrps-1:0]          setback_o,
   output logic [NumGrps-1:0]          recovery_req_o,
   output logic [NumGrps-1:0]          grp_in_indep_o,
   output logic [NumGrps-1:0]          fault_o,
   output logic [NumGrps*CntWidth-1:0] mismatch_cnt_o
);

   for (genvar g = 0; g < NumGrps; g++) begin : gen_grp
      hmr_dmr_grp_fsm #(
         .DMRFixed        (DMRFixed),
         .DefaultInDMR    (DefaultInDMR),
         .RapidRecovery   (RapidRecovery),
         .SetbackCycles   (SetbackCycles),
         .RecoveryTimeout (RecoveryTimeout),
         .CntWidth        (CntWidth)
      ) i_grp_fsm (
         .clk_i            (clk_i),
         .rst_i            (rst_i),
         .dmr_enable_i     (dmr_enable_i[g]),
         .rapid_rec_en_i   (rapid_rec_en_i[g]),
         .force_recovery_i (force_recovery_i[g]),
         .fetch_en_i       (fetch_en_i[g]),
         .cores_synch_i    (cores_synch_i[g]),
         .dmr_error_i      (dmr_error_i[g]),
         .recovery_done_i  (recovery_done_i[g]),
         .fault_clr_i      (fault_clr_i[g]),
         .mismatch_clr_i   (mismatch_clr_i[g]),
         .setback_o        (setback_o[g]),
         .recovery_req_o   (recovery_req_o[g]),
         .grp_in_indep_o   (grp_in_indep_o[g]),
         .fault_o          (fault_o[g]),
         .mismatch_cnt_o   (mismatch_cnt_o[g*CntWidth +: CntWidth])
      );
   end

endmodule

// File: tb/tb_hmr_dmr_multi_ctrl.sv
// Bench: two controller builds (rapid-recovery/short-timeout/2-bit counters, and DMR-fixed
// setback-only) share stimulus; a mode-level model is compared every cycle plus literal checks.
module tb_hmr_dmr_multi_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] dmr_enable, rapid_rec_en, force_recovery, fetch_en, cores_synch;
   logic [3:0] dmr_error, recovery_done, fault_clr, mismatch_clr;

   logic [3:0]  sb_a, req_a, indep_a, fault_a;
   logic [7:0]  cnt_a;
   logic [3:0]  sb_b, req_b, indep_b, fault_b;
   logic [31:0] cnt_b;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   hmr_dmr_multi_ctrl #(
      .NumGrps(4), .DMRFixed(1'b0), .DefaultInDMR(1'b0), .RapidRecovery(1'b1),
      .SetbackCycles(4), .RecoveryTimeout(16), .CntWidth(2)
   ) dut_a (
      .clk_i(clk), .rst_i(rst), .dmr_enable_i(dmr_enable), .rapid_rec_en_i(rapid_rec_en),
      .force_recovery_i(force_recovery), .fetch_en_i(fetch_en), .cores_synch_i(cores_synch),
      .dmr_error_i(dmr_error), .recovery_done_i(recovery_done), .fault_clr_i(fault_clr),
      .mismatch_clr_i(mismatch_clr), .setback_o(sb_a), .recovery_req_o(req_a),
      .grp_in_indep_o(indep_a), .fault_o(fault_a), .mismatch_cnt_o(cnt_a)
   );

   hmr_dmr_multi_ctrl #(
      .NumGrps(4), .DMRFixed(1'b1), .DefaultInDMR(1'b1), .RapidRecovery(1'b0),
      .SetbackCycles(4), .RecoveryTimeout(256), .CntWidth(8)
   ) dut_b (
      .clk_i(clk), .rst_i(rst), .dmr_enable_i(dmr_enable), .rapid_rec_en_i(rapid_rec_en),
      .force_recovery_i(force_recovery), .fetch_en_i(fetch_en), .cores_synch_i(cores_synch),
      .dmr_error_i(dmr_error), .recovery_done_i(recovery_done), .fault_clr_i(fault_clr),
      .mismatch_clr_i(mismatch_clr), .setback_o(sb_b), .recovery_req_o(req_b),
      .grp_in_indep_o(indep_b), .fault_o(fault_b), .mismatch_cnt_o(cnt_b)
   );

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s t=%0t got %0h expected %0h", name, $time, got, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   localparam int M_INDEP = 0, M_LOCK = 1, M_SB = 2, M_REC = 3, M_FLT = 4;
   localparam int SB_CYC  = 4;
   int m_mode [2][4];
   int m_aux  [2][4];
   int m_cnt  [2][4];
   bit model_ok = 1'b0;

   task automatic model_step(input int i, input int g, input bit fixed, input bit rr,
                             input int tout, input int cmax);
      bit en, inc;
      int nxt;
      if (rst) begin
         m_mode[i][g] = fixed ? M_LOCK : M_INDEP;
         m_aux[i][g]  = 0;
         m_cnt[i][g]  = 0;
         return;
      end
      en  = dmr_enable[g] || fixed;
      inc = 1'b0;
      nxt = m_mode[i][g];
      case (m_mode[i][g])
         M_INDEP: if (en && (!fetch_en[g] || cores_synch[g])) nxt = M_LOCK;
         M_LOCK: begin
            if (dmr_error[g]) begin
               inc = 1'b1;
               if (rr && rapid_rec_en[g]) begin nxt = M_REC; m_aux[i][g] = 0; end
               else begin nxt = M_SB; m_aux[i][g] = SB_CYC; end
            end else if (force_recovery[g] && rr) begin
               nxt = M_REC; m_aux[i][g] = 0;
            end else if (!en) nxt = M_INDEP;
         end
         M_SB: begin
            inc = dmr_error[g];
            m_aux[i][g]--;
            if (m_aux[i][g] == 0) nxt = M_LOCK;
         end
         M_REC: begin
            inc = dmr_error[g];
            if (recovery_done[g]) nxt = M_LOCK;
            else if (m_aux[i][g] == tout - 1) nxt = M_FLT;
            else m_aux[i][g]++;
         end
         M_FLT: if (fault_clr[g]) nxt = fixed ? M_LOCK : M_INDEP;
         default: nxt = M_INDEP;
      endcase
      m_mode[i][g] = nxt;
      if (mismatch_clr[g]) m_cnt[i][g] = 0;
      else if (inc && m_cnt[i][g] < cmax) m_cnt[i][g]++;
   endtask

   always @(posedge clk) begin
      for (int g = 0; g < 4; g++) begin
         model_step(0, g, 1'b0, 1'b1, 16, 3);
         model_step(1, g, 1'b1, 1'b0, 256, 255);
      end
      model_ok = 1'b1;
   end

   // Compare on the falling edge, well away from the active edge.
   always @(negedge clk) begin
      logic [3:0]  e_sb [2], e_req [2], e_ind [2], e_flt [2];
      logic [7:0]  e_cnt_a;
      logic [31:0] e_cnt_b;
      if (model_ok) begin
         for (int i = 0; i < 2; i++)
            for (int g = 0; g < 4; g++) begin
               e_sb[i][g]  = (m_mode[i][g] == M_SB);
               e_req[i][g] = (m_mode[i][g] == M_REC);
               e_ind[i][g] = (m_mode[i][g] == M_INDEP);
               e_flt[i][g] = (m_mode[i][g] == M_FLT);
            end
         for (int g = 0; g < 4; g++) begin
            e_cnt_a[g*2 +: 2] = 2'(m_cnt[0][g]);
            e_cnt_b[g*8 +: 8] = 8'(m_cnt[1][g]);
         end
         chk("model_a_setback", 32'(sb_a), 32'(e_sb[0]));
         chk("model_a_recreq",  32'(req_a), 32'(e_req[0]));
         chk("model_a_indep",   32'(indep_a), 32'(e_ind[0]));
         chk("model_a_fault",   32'(fault_a), 32'(e_flt[0]));
         chk("model_a_cnt",     32'(cnt_a), 32'(e_cnt_a));
         chk("model_b_setback", 32'(sb_b), 32'(e_sb[1]));
         chk("model_b_recreq",  32'(req_b), 32'(e_req[1]));
         chk("model_b_indep",   32'(indep_b), 32'(e_ind[1]));
         chk("model_b_fault",   32'(fault_b), 32'(e_flt[1]));
         chk("model_b_cnt",     32'(cnt_b), e_cnt_b);
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int n;
      int idx;
      rst = 1'b1;
      dmr_enable = '0; rapid_rec_en = '0; force_recovery = '0; fetch_en = '0;
      cores_synch = '0; dmr_error = '0; recovery_done = '0; fault_clr = '0; mismatch_clr = '0;
      repeat (3) cyc();
      chk("rst_a_indep", 32'(indep_a), 32'h0000000F);
      chk("rst_a_outs",  32'({sb_a, req_a, fault_a}), 32'h0);
      chk("rst_a_cnt",   32'(cnt_a), 32'h0);
      chk("rst_b_indep", 32'(indep_b), 32'h0);
      chk("rst_b_cnt",   cnt_b, 32'h0);

      // group 0 enters lockstep with fetch disabled
      rst = 1'b0;
      dmr_enable = 4'b0001;
      cyc();
      chk("enter_a_indep", 32'(indep_a), 32'h0000000E);

      // setback window of four cycles
      dmr_error = 4'b0001;
      cyc();
      dmr_error = '0;
      n = 0;
      for (int k = 0; k < 8; k++) begin
         if (sb_a[0]) n++;
         cyc();
      end
      chk("setback_len", 32'(n), 32'd4);
      chk("setback_cnt0", 32'(cnt_a[1:0]), 32'd1);

      // rapid recovery, done ten cycles after entry
      rapid_rec_en = 4'b0001;
      dmr_error = 4'b0001;
      cyc();
      dmr_error = '0;
      chk("rr_req", 32'(req_a[0]), 32'd1);
      repeat (9) cyc();
      chk("rr_req_held", 32'(req_a[0]), 32'd1);
      recovery_done = 4'b0001;
      cyc();
      recovery_done = '0;
      chk("rr_done_req", 32'(req_a[0]), 32'd0);
      chk("rr_done_cnt", 32'(cnt_a[1:0]), 32'd2);

      // timeout into fault
      dmr_error = 4'b0001;
      cyc();
      dmr_error = '0;
      idx = -1;
      for (int k = 0; k < 40; k++) begin
         if (fault_a[0] && idx < 0) idx = k;
         cyc();
      end
      chk("timeout_cycle", 32'(idx), 32'd16);
      fault_clr = 4'b0001;
      cyc();
      fault_clr = '0;
      chk("fault_clr_indep", 32'(indep_a[0]), 32'd1);
      chk("fault_clr_fault", 32'(fault_a[0]), 32'd0);
      cyc();

      // saturation and clear-wins
      rapid_rec_en = '0;
      mismatch_clr = 4'b0001;
      cyc();
      mismatch_clr = '0;
      chk("clr_cnt", 32'(cnt_a[1:0]), 32'd0);
      dmr_error = 4'b0001;
      repeat (5) cyc();
      dmr_error = '0;
      chk("sat_a", 32'(cnt_a[1:0]), 32'd3);
      chk("sat_b", 32'(cnt_b[7:0]), 32'd5);
      dmr_error = 4'b0001;
      mismatch_clr = 4'b0001;
      cyc();
      dmr_error = '0;
      mismatch_clr = '0;
      chk("clr_wins_a", 32'(cnt_a[1:0]), 32'd0);
      chk("clr_wins_b", 32'(cnt_b[7:0]), 32'd0);
      repeat (5) cyc();

      // entry gated by core synchronisation, then simultaneous errors on groups 1 and 3
      dmr_enable = 4'hF;
      fetch_en = 4'hF;
      cores_synch = 4'h0;
      repeat (2) cyc();
      chk("synch_gate", 32'(indep_a), 32'h0000000E);
      cores_synch = 4'hF;
      cyc();
      chk("synch_enter", 32'(indep_a), 32'h0);
      dmr_error = 4'b1010;
      cyc();
      dmr_error = '0;
      chk("multi_sb_a", 32'(sb_a), 32'h0000000A);
      chk("multi_sb_b", 32'(sb_b), 32'h0000000A);
      repeat (5) cyc();

      // forced recovery only where the recovery path exists
      force_recovery = 4'b0100;
      cyc();
      force_recovery = '0;
      chk("force_a", 32'(req_a), 32'h4);
      chk("force_b", 32'(req_b), 32'h0);
      recovery_done = 4'b0100;
      cyc();
      recovery_done = '0;
      chk("force_done", 32'(req_a), 32'h0);

      // enable drop during setback is deferred until the window ends
      dmr_error = 4'b0001;
      cyc();
      dmr_error = '0;
      dmr_enable = '0;
      cyc();
      chk("drop_in_sb", 32'({indep_a[0], sb_a[0]}), 32'b01);
      repeat (4) cyc();
      chk("drop_exit_a", 32'(indep_a), 32'h0000000F);
      chk("fixed_b",     32'(indep_b), 32'h0);

      // reset in the middle of a restore
      dmr_enable = 4'b0001;
      fetch_en = '0;
      repeat (2) cyc();
      rapid_rec_en = 4'b0001;
      dmr_error = 4'b0001;
      cyc();
      dmr_error = '0;
      cyc();
      chk("pre_rst_req", 32'(req_a[0]), 32'd1);
      rst = 1'b1;
      cyc();
      chk("midrst_a", 32'({sb_a, req_a, fault_a, indep_a}), 32'h000F);
      chk("midrst_cnt_a", 32'(cnt_a), 32'h0);
      chk("midrst_b", 32'({sb_b, req_b, fault_b, indep_b}), 32'h0);
      rst = 1'b0;
      repeat (3) cyc();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
